// File: rtl/pipe_pkg.sv
// Shared helpers for the elastic valid/ready pipeline.
package pipe_pkg;

    function automatic int count_w(input int depth, input int skid);
        return $clog2(depth + skid + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic pipeline stage: valid bit plus payload, loaded on ready, killed by flush.
module pipe_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             kill,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] payload_q, payload_d;

    // Payload only captures live entries so bubbles never overwrite held data.
    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        if (kill) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = valid_in;
            if (valid_in) begin
                payload_d = data_in;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = payload_q;

endmodule

// File: rtl/elastic_pipe.sv
// Parametrised valid/ready pipeline of DEPTH stages with an optional 1-entry input skid buffer.
module elastic_pipe
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int SKID  = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIDTH-1:0]                 out_data,
    output logic [count_w(DEPTH, SKID)-1:0]  count
);

    localparam int CW = count_w(DEPTH, SKID);

    if (DEPTH < 1 || (SKID != 0 && SKID != 1)) begin : g_bad_param
        $error("elastic_pipe: DEPTH must be >= 1 and SKID must be 0 or 1");
    end

    logic [DEPTH-1:0] v;
    logic [DEPTH:0]   rdy;
    logic [WIDTH-1:0] d [DEPTH];
    logic             src_valid;
    logic [WIDTH-1:0] src_data;
    logic             skid_cnt;
    logic [CW-1:0]    live;

    // Ready ripples from the output back toward stage 0.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            rdy[DEPTH-1-k] = ~v[DEPTH-1-k] | rdy[DEPTH-k];
        end
    end

    if (SKID == 1) begin : g_skid
        logic             skid_valid_q, skid_valid_d;
        logic [WIDTH-1:0] skid_data_q, skid_data_d;

        always_comb begin
            skid_valid_d = skid_valid_q;
            skid_data_d  = skid_data_q;
            if (flush) begin
                skid_valid_d = 1'b0;
            end else if (skid_valid_q) begin
                if (rdy[0]) begin
                    skid_valid_d = 1'b0;
                end
            end else if (in_valid && !rdy[0]) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                skid_valid_q <= 1'b0;
                skid_data_q  <= '0;
            end else begin
                skid_valid_q <= skid_valid_d;
                skid_data_q  <= skid_data_d;
            end
        end

        // A held skid entry always goes ahead of new input to keep FIFO order.
        assign in_ready  = ~skid_valid_q & ~flush;
        assign src_valid = skid_valid_q | in_valid;
        assign src_data  = skid_valid_q ? skid_data_q : in_data;
        assign skid_cnt  = skid_valid_q;
    end else begin : g_noskid
        assign in_ready  = rdy[0] & ~flush;
        assign src_valid = in_valid;
        assign src_data  = in_data;
        assign skid_cnt  = 1'b0;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             vi;
        logic [WIDTH-1:0] di;
        if (i == 0) begin : g_first
            assign vi = src_valid;
            assign di = src_data;
        end else begin : g_next
            assign vi = v[i-1];
            assign di = d[i-1];
        end
        pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk       (clk),
            .reset     (reset),
            .load      (rdy[i]),
            .kill      (flush),
            .valid_in  (vi),
            .data_in   (di),
            .valid_out (v[i]),
            .data_out  (d[i])
        );
    end

    always_comb begin
        live = CW'(skid_cnt);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            live = live + CW'(v[i]);
        end
    end

    assign count     = live;
    assign out_valid = v[DEPTH-1] & ~flush;
    assign out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_elastic_pipe.sv
// Directed bench for elastic_pipe: DEPTH=2/SKID=1 main instance plus DEPTH=1 and DEPTH=4 without skid.
module tb_elastic_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    logic        a_fl, a_iv, a_ir, a_ov, a_or;
    logic [31:0] a_in, a_out;
    logic [1:0]  a_cnt;

    logic        b_iv, b_ir, b_ov, b_or;
    logic [15:0] b_in, b_out;
    logic [0:0]  b_cnt;

    logic        c_iv, c_ir, c_ov, c_or;
    logic [15:0] c_in, c_out;
    logic [2:0]  c_cnt;

    logic [15:0] qb[$];
    logic [15:0] qc[$];

    elastic_pipe #(.WIDTH(32), .DEPTH(2), .SKID(1)) u_a (
        .clk(clk), .reset(reset), .flush(a_fl), .in_valid(a_iv), .in_ready(a_ir),
        .in_data(a_in), .out_valid(a_ov), .out_ready(a_or), .out_data(a_out), .count(a_cnt)
    );

    elastic_pipe #(.WIDTH(16), .DEPTH(1), .SKID(0)) u_b (
        .clk(clk), .reset(reset), .flush(1'b0), .in_valid(b_iv), .in_ready(b_ir),
        .in_data(b_in), .out_valid(b_ov), .out_ready(b_or), .out_data(b_out), .count(b_cnt)
    );

    elastic_pipe #(.WIDTH(16), .DEPTH(4), .SKID(0)) u_c (
        .clk(clk), .reset(reset), .flush(1'b0), .in_valid(c_iv), .in_ready(c_ir),
        .in_data(c_in), .out_valid(c_ov), .out_ready(c_or), .out_data(c_out), .count(c_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic iv, input logic [31:0] din, input logic ordy, input logic fl);
        a_iv = iv;
        a_in = din;
        a_or = ordy;
        a_fl = fl;
        #1;
    endtask

    // Checks then applies one cycle of B/C traffic against the queue models.
    task automatic step_bc();
        chk("b_count", 64'(b_cnt), 64'(qb.size()));
        chk("c_count", 64'(c_cnt), 64'(qc.size()));
        if (b_ov && b_or) begin
            chk("b_order", 64'(b_out), 64'(qb[0]));
            void'(qb.pop_front());
        end
        if (c_ov && c_or) begin
            chk("c_order", 64'(c_out), 64'(qc[0]));
            void'(qc.pop_front());
        end
        if (b_iv && b_ir) qb.push_back(b_in);
        if (c_iv && c_ir) qc.push_back(c_in);
        tick();
    endtask

    initial begin
        a_fl = 0; a_iv = 0; a_in = '0; a_or = 0;
        b_iv = 0; b_in = '0; b_or = 0;
        c_iv = 0; c_in = '0; c_or = 0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("rst_out_valid", 64'(a_ov), 64'd0);
        chk("rst_out_data", 64'(a_out), 64'd0);
        chk("rst_count", 64'(a_cnt), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_in_ready", 64'(a_ir), 64'd1);
        tick();

        // Stream 1..8 with the consumer always ready.
        for (int i = 0; i < 11; i++) begin
            drive_a(i < 8, 32'(i + 1), 1'b1, 1'b0);
            chk("t1_in_ready", 64'(a_ir), 64'd1);
            chk("t1_count_le2", 64'(a_cnt <= 2'd2), 64'd1);
            if (i >= 2 && i < 10) begin
                chk("t1_out_valid", 64'(a_ov), 64'd1);
                chk("t1_out_data", 64'(a_out), 64'(i - 1));
            end else begin
                chk("t1_out_idle", 64'(a_ov), 64'd0);
            end
            tick();
        end
        chk("t1_count_end", 64'(a_cnt), 64'd0);

        // Back-pressure fills both stages and the skid.
        drive_a(1, 32'hA, 0, 0); chk("t2_ir0", 64'(a_ir), 64'd1); tick();
        drive_a(1, 32'hB, 0, 0); chk("t2_ir1", 64'(a_ir), 64'd1); tick();
        drive_a(1, 32'hC, 0, 0); chk("t2_ir2", 64'(a_ir), 64'd1); tick();
        drive_a(1, 32'hD, 1, 0);
        chk("t2_ir_full", 64'(a_ir), 64'd0);
        chk("t2_count_full", 64'(a_cnt), 64'd3);
        chk("t2_out_a", 64'(a_out), 64'hA);
        chk("t2_ov_a", 64'(a_ov), 64'd1);
        tick();
        drive_a(1, 32'hD, 1, 0);
        chk("t2_ir_reopen", 64'(a_ir), 64'd1);
        chk("t2_out_b", 64'(a_out), 64'hB);
        chk("t2_count_2", 64'(a_cnt), 64'd2);
        tick();
        drive_a(0, 32'h0, 1, 0);
        chk("t2_out_c", 64'(a_out), 64'hC);
        chk("t2_count_c", 64'(a_cnt), 64'd2);
        tick();
        drive_a(0, 32'h0, 1, 0);
        chk("t2_out_d", 64'(a_out), 64'hD);
        chk("t2_count_d", 64'(a_cnt), 64'd1);
        tick();
        drive_a(0, 32'h0, 1, 0);
        chk("t2_drained", 64'(a_ov), 64'd0);
        chk("t2_count_0", 64'(a_cnt), 64'd0);

        // Bubble collapse.
        drive_a(1, 32'h10, 0, 0); tick();
        drive_a(0, 32'h0, 0, 0); tick(); tick(); tick();
        drive_a(1, 32'h11, 0, 0); tick();
        drive_a(0, 32'h0, 0, 0);
        chk("t3_count", 64'(a_cnt), 64'd2);
        chk("t3_ov", 64'(a_ov), 64'd1);
        chk("t3_out_10", 64'(a_out), 64'h10);
        a_or = 1'b1; #1;
        tick();
        drive_a(0, 32'h0, 1, 0);
        chk("t3_out_11", 64'(a_out), 64'h11);
        chk("t3_count_1", 64'(a_cnt), 64'd1);
        tick();
        drive_a(0, 32'h0, 1, 0);
        chk("t3_drained", 64'(a_ov), 64'd0);

        // Flush with three entries in flight.
        drive_a(1, 32'h41, 0, 0); tick();
        drive_a(1, 32'h42, 0, 0); tick();
        drive_a(1, 32'h43, 0, 0); tick();
        drive_a(1, 32'h99, 1, 1);
        chk("t4_flush_ov", 64'(a_ov), 64'd0);
        chk("t4_flush_ir", 64'(a_ir), 64'd0);
        chk("t4_pre_count", 64'(a_cnt), 64'd3);
        tick();
        drive_a(1, 32'h20, 1, 0);
        chk("t4_count_0", 64'(a_cnt), 64'd0);
        chk("t4_ov_0", 64'(a_ov), 64'd0);
        chk("t4_ir_1", 64'(a_ir), 64'd1);
        tick();
        drive_a(0, 32'h0, 1, 0);
        chk("t4_count_1", 64'(a_cnt), 64'd1);
        tick();
        drive_a(0, 32'h0, 1, 0);
        chk("t4_ov_20", 64'(a_ov), 64'd1);
        chk("t4_out_20", 64'(a_out), 64'h20);
        tick();
        drive_a(0, 32'h0, 1, 0);
        chk("t4_count_end", 64'(a_cnt), 64'd0);

        // Asynchronous reset between edges while output is valid.
        drive_a(1, 32'h30, 0, 0); tick();
        drive_a(1, 32'h31, 0, 0); tick();
        drive_a(0, 32'h0, 0, 0);
        chk("t5_pre_ov", 64'(a_ov), 64'd1);
        chk("t5_pre_out", 64'(a_out), 64'h30);
        #2 reset = 1'b1;
        #1;
        chk("t5_ov", 64'(a_ov), 64'd0);
        chk("t5_out", 64'(a_out), 64'd0);
        chk("t5_count", 64'(a_cnt), 64'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t5_ir", 64'(a_ir), 64'd1);
        chk("t5_count_after", 64'(a_cnt), 64'd0);
        tick();

        // Unstalled latency for DEPTH=1 and DEPTH=4.
        b_iv = 1; b_in = 16'h55; b_or = 1;
        c_iv = 1; c_in = 16'h55; c_or = 1;
        #1; tick();
        b_iv = 0; c_iv = 0; #1;
        chk("t6_b_lat_ov", 64'(b_ov), 64'd1);
        chk("t6_b_lat_data", 64'(b_out), 64'h55);
        chk("t6_c_lat_ov1", 64'(c_ov), 64'd0);
        tick();
        chk("t6_b_gone", 64'(b_ov), 64'd0);
        chk("t6_c_lat_ov2", 64'(c_ov), 64'd0);
        tick();
        chk("t6_c_lat_ov3", 64'(c_ov), 64'd0);
        tick();
        chk("t6_c_lat_ov4", 64'(c_ov), 64'd1);
        chk("t6_c_lat_data", 64'(c_out), 64'h55);
        tick();
        chk("t6_c_gone", 64'(c_ov), 64'd0);

        // Random valid/ready traffic, then drain.
        for (int i = 0; i < 80; i++) begin
            b_iv = 1'($urandom_range(0, 1));
            b_in = 16'(16'h100 + i);
            b_or = ($urandom_range(0, 3) != 0);
            c_iv = ($urandom_range(0, 3) != 0);
            c_in = 16'(16'h200 + i);
            c_or = 1'($urandom_range(0, 1));
            #1;
            step_bc();
        end
        for (int i = 0; i < 12; i++) begin
            b_iv = 0; c_iv = 0; b_or = 1; c_or = 1;
            #1;
            step_bc();
        end
        chk("t6_b_sb_empty", 64'(qb.size()), 64'd0);
        chk("t6_c_sb_empty", 64'(qc.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
